// File: rtl/rvfi_seq_pkg.sv
// Shared types for the RVFI retirement sequencer: FIFO entry payload,
// sequencer FSM states and field widths.
package rvfi_seq_pkg;

    localparam int unsigned ORDER_W  = 8;
    localparam int unsigned INSN_W   = 32;
    // PCs are stored at the widest supported XLEN; narrower cores zero-extend.
    localparam int unsigned XLEN_MAX = 64;

    typedef struct packed {
        logic [ORDER_W-1:0]  order;
        logic [INSN_W-1:0]   insn;
        logic [XLEN_MAX-1:0] pre_pc;
        logic [XLEN_MAX-1:0] post_pc;
        logic                trap;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HALT   = 2'd2
    } state_e;

endpackage

// File: rtl/rvfi_seq_fifo.sv
// Retirement FIFO: up to NRET writes per cycle into consecutive slots,
// one read per cycle from the head. Storage itself is not reset.
module rvfi_seq_fifo
    import rvfi_seq_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [$clog2(DEPTH+1)-1:0]   push_cnt_i,
    input  entry_t [NRET-1:0]            push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i  && !flush_i;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NRET; k++) begin
            if (do_push && (CW'(k) < push_cnt_i)) begin
                mem_q[wr_ptr_q + PW'(k)] <= push_data_i[k];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (do_push ? push_cnt_i : CW'(0)) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Serializes NRET parallel RVFI retirement channels into one ordered stream,
// flagging dropped groups (overflow) and breaks in the retirement order.
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*8-1:0]       in_order,
    input  logic [NRET*32-1:0]      in_insn,
    input  logic [NRET*XLEN-1:0]    in_pre_pc,
    input  logic [NRET*XLEN-1:0]    in_post_pc,
    input  logic [NRET-1:0]         in_trap,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_order,
    output logic [31:0]             out_insn,
    output logic [XLEN-1:0]         out_pre_pc,
    output logic [XLEN-1:0]         out_post_pc,
    output logic                    out_trap,
    output logic                    overflow,
    output logic                    order_err,
    input  logic                    flush
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    state_e               state_q, state_d;
    logic                 overflow_q, overflow_d;
    logic                 order_err_q, order_err_d;
    logic [ORDER_W-1:0]   exp_order_q, exp_order_d;
    logic                 seen_pop_q, seen_pop_d;

    entry_t [NRET-1:0]    push_data;
    logic [CW-1:0]        nvalid;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_after;
    logic                 push;
    logic                 pop;
    logic                 fits;
    entry_t               head;
    logic                 unused_pc_hi;

    // Compact valid channels into slots 0..nvalid-1, lowest channel first.
    always_comb begin
        int unsigned rank;
        entry_t      ent;
        push_data = '0;
        rank      = 0;
        for (int i = 0; i < NRET; i++) begin
            ent         = '0;
            ent.order   = in_order[i*ORDER_W +: ORDER_W];
            ent.insn    = in_insn[i*INSN_W +: INSN_W];
            ent.pre_pc  = XLEN_MAX'(in_pre_pc[i*XLEN +: XLEN]);
            ent.post_pc = XLEN_MAX'(in_post_pc[i*XLEN +: XLEN]);
            ent.trap    = in_trap[i];
            if (in_valid[i]) begin
                for (int k = 0; k < NRET; k++) begin
                    if (rank == k) begin
                        push_data[k] = ent;
                    end
                end
                rank = rank + 1;
            end
        end
        nvalid = CW'(rank);
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // Credit is based on pre-cycle occupancy only; a same-cycle pop does not help.
    assign fits      = nvalid <= (CW'(DEPTH) - count);

    always_comb begin
        state_d     = state_q;
        overflow_d  = overflow_q;
        order_err_d = order_err_q;
        exp_order_d = exp_order_q;
        seen_pop_d  = seen_pop_q;
        push        = 1'b0;
        count_after = count;
        if (flush) begin
            state_d     = EMPTY;
            overflow_d  = 1'b0;
            order_err_d = 1'b0;
            exp_order_d = '0;
            seen_pop_d  = 1'b0;
        end else begin
            if (pop) begin
                exp_order_d = ORDER_W'(out_order + 8'd1);
                seen_pop_d  = 1'b1;
                if (seen_pop_q && (out_order != exp_order_q)) begin
                    order_err_d = 1'b1;
                end
            end
            case (state_q)
                HALT: state_d = HALT;
                default: begin
                    if ((nvalid != '0) && !fits) begin
                        overflow_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        push        = (nvalid != '0);
                        count_after = count + (push ? nvalid : CW'(0)) - CW'(pop);
                        state_d     = (count_after != '0) ? STREAM : EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            exp_order_q <= '0;
            seen_pop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
            exp_order_q <= exp_order_d;
            seen_pop_q  <= seen_pop_d;
        end
    end

    rvfi_seq_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (push),
        .push_cnt_i  (nvalid),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign out_order    = head.order;
    assign out_insn     = head.insn;
    assign out_pre_pc   = XLEN'(head.pre_pc);
    assign out_post_pc  = XLEN'(head.post_pc);
    assign out_trap     = head.trap;
    assign unused_pc_hi = ^{head.pre_pc, head.post_pc};
    assign overflow     = overflow_q;
    assign order_err    = order_err_q;

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed bench for rvfi_retire_sequencer (NRET=2, XLEN=32, DEPTH=4).
module tb_rvfi_retire_sequencer;
    import rvfi_seq_pkg::*;

    localparam int unsigned NRET  = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRET-1:0]      in_valid;
    logic [NRET*8-1:0]    in_order;
    logic [NRET*32-1:0]   in_insn;
    logic [NRET*XLEN-1:0] in_pre_pc;
    logic [NRET*XLEN-1:0] in_post_pc;
    logic [NRET-1:0]      in_trap;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_order;
    logic [31:0]          out_insn;
    logic [XLEN-1:0]      out_pre_pc;
    logic [XLEN-1:0]      out_post_pc;
    logic                 out_trap;
    logic                 overflow;
    logic                 order_err;
    logic                 flush;

    int checks = 0;
    int errors = 0;

    rvfi_retire_sequencer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_insn     (in_insn),
        .in_pre_pc   (in_pre_pc),
        .in_post_pc  (in_post_pc),
        .in_trap     (in_trap),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_order   (out_order),
        .out_insn    (out_insn),
        .out_pre_pc  (out_pre_pc),
        .out_post_pc (out_post_pc),
        .out_trap    (out_trap),
        .overflow    (overflow),
        .order_err   (order_err),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [7:0] o);
        return 32'hA500_0000 | 32'(o);
    endfunction

    function automatic logic [31:0] pc_of(input logic [7:0] o);
        return 32'h0000_1000 + (32'(o) << 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1);
        in_valid   = v;
        in_order   = {o1, o0};
        in_insn    = {insn_of(o1), insn_of(o0)};
        in_pre_pc  = {pc_of(o1), pc_of(o0)};
        in_post_pc = {pc_of(o1) + 32'd4, pc_of(o0) + 32'd4};
        in_trap    = {o1[0], o0[0]};
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(2'b00, 8'd0, 8'd0);
        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        #9 reset = 1'b0;
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_order_err", 32'(order_err), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(EMPTY));

        // Two channels in one cycle: lower channel emitted first, one cycle later.
        drive(2'b11, 8'd5, 8'd6); out_ready = 1'b1;
        tick(); idle();
        check("pair_v0", 32'(out_valid), 32'd1);
        check("pair_o0", 32'(out_order), 32'd5);
        check("pair_insn0", out_insn, insn_of(8'd5));
        check("pair_pre0", out_pre_pc, pc_of(8'd5));
        check("pair_post0", out_post_pc, pc_of(8'd5) + 32'd4);
        check("pair_trap0", 32'(out_trap), 32'd1);
        tick();
        check("pair_o1", 32'(out_order), 32'd6);
        check("pair_trap1", 32'(out_trap), 32'd0);
        tick();
        check("pair_empty", 32'(out_valid), 32'd0);
        check("pair_ovf", 32'(overflow), 32'd0);
        check("pair_oerr", 32'(order_err), 32'd0);

        // Overflow: third group dropped, HALT ignores pushes, drain of 4.
        do_flush(); out_ready = 1'b0;
        drive(2'b11, 8'd10, 8'd11); tick();
        drive(2'b11, 8'd12, 8'd13); tick();
        check("ovf_not_yet", 32'(overflow), 32'd0);
        drive(2'b11, 8'd14, 8'd15); tick();
        drive(2'b01, 8'd20, 8'd21); tick(); idle();
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_state", 32'(dut.state_q), 32'(HALT));
        check("ovf_head_stable", 32'(out_order), 32'd10);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_v", 32'(out_valid), 32'd1);
            check("ovf_drain_o", 32'(out_order), 32'(10 + k));
            tick();
        end
        check("ovf_drained", 32'(out_valid), 32'd0);
        check("ovf_still_halt", 32'(dut.state_q), 32'(HALT));
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_oerr", 32'(order_err), 32'd0);

        // count=3, pop plus single push in the same cycle.
        do_flush(); out_ready = 1'b0;
        check("flush_clears_ovf", 32'(overflow), 32'd0);
        check("flush_state", 32'(dut.state_q), 32'(EMPTY));
        drive(2'b11, 8'd30, 8'd31); tick();
        drive(2'b01, 8'd32, 8'd0); tick();
        out_ready = 1'b1;
        drive(2'b10, 8'd0, 8'd33); tick(); idle(); out_ready = 1'b0;
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_head", 32'(out_order), 32'd31);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("pp_drain_o", 32'(out_order), 32'(31 + k));
            tick();
        end
        check("pp_empty", 32'(out_valid), 32'd0);
        check("pp_oerr", 32'(order_err), 32'd0);

        // Order wrap 254,255,0 is legal; a jump to 2 is not.
        do_flush(); out_ready = 1'b0;
        drive(2'b11, 8'd254, 8'd255); tick();
        drive(2'b11, 8'd0, 8'd2); tick(); idle();
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("wrap_oerr", 32'(order_err), 32'd0);
        check("wrap_head", 32'(out_order), 32'd2);
        tick();
        check("jump_oerr", 32'(order_err), 32'd1);
        check("jump_empty", 32'(out_valid), 32'd0);

        // flush beats a same-cycle push and pop.
        out_ready = 1'b0;
        drive(2'b11, 8'd90, 8'd91); tick();
        flush = 1'b1; out_ready = 1'b1;
        drive(2'b01, 8'd92, 8'd0); tick();
        flush = 1'b0; idle();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_state", 32'(dut.state_q), 32'(EMPTY));
        check("fl_oerr", 32'(order_err), 32'd0);
        check("fl_ovf", 32'(overflow), 32'd0);
        tick();
        check("fl_discarded", 32'(out_valid), 32'd0);
        drive(2'b01, 8'd200, 8'd0); tick(); idle();
        check("fl_first", 32'(out_order), 32'd200);
        tick();
        check("fl_first_unchecked", 32'(order_err), 32'd0);

        // Asynchronous reset mid-cycle with two entries buffered.
        out_ready = 1'b0;
        drive(2'b11, 8'd40, 8'd41); tick();
        drive(2'b01, 8'd42, 8'd0); tick(); idle();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_head", 32'(out_order), 32'd41);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        #10 reset = 1'b0;
        check("rst_released_valid", 32'(out_valid), 32'd0);
        drive(2'b11, 8'd77, 8'd78); out_ready = 1'b1;
        tick(); idle();
        check("rst_first", 32'(out_order), 32'd77);
        tick();
        check("rst_second", 32'(out_order), 32'd78);
        tick();
        check("rst_oerr", 32'(order_err), 32'd0);
        check("rst_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_retire_sequencer.md
RVFI_RETIRE_SEQUENCER -- requirements
Module: rvfi_retire_sequencer

Interface
REQ-001 Parameter NRET, default 2: number of parallel retirement channels in.
REQ-002 Parameter XLEN, default 32: register and PC width.
REQ-003 Parameter DEPTH, default 4: retirement FIFO entries; power of 2; DEPTH >= NRET.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  NRET  per-channel retirement valid.
REQ-007 in_order  in  NRET*8  per-channel retirement order.
REQ-008 in_insn  in  NRET*32  per-channel instruction word.
REQ-009 in_pre_pc  in  NRET*XLEN  per-channel PC before the instruction.
REQ-010 in_post_pc  in  NRET*XLEN  per-channel PC after the instruction.
REQ-011 in_trap  in  NRET  per-channel trap flag.
REQ-012 out_valid  out  1  serialized retirement available.
REQ-013 out_ready  in  1  downstream checker accepts.
REQ-014 out_order, out_insn, out_pre_pc, out_post_pc, out_trap  out  8/32/XLEN/XLEN/1  head-entry fields.
REQ-015 overflow  out  1  sticky: a retirement group was dropped.
REQ-016 order_err  out  1  sticky: an emitted order broke the +1 sequence.
REQ-017 flush  in  1  synchronous clear of FIFO, state and sticky flags.

Function
REQ-018 The block SHALL serialize a group of up to NRET valid channels in one cycle into the FIFO in ascending channel index, lowest index first.
REQ-019 A group SHALL be accepted only if popcount(in_valid) <= DEPTH - count, where count is the pre-cycle occupancy; a same-cycle pop grants no credit.
REQ-020 A group that fails REQ-019 SHALL be dropped whole (no partial push); overflow SHALL then set and the FSM SHALL enter HALT.
REQ-021 FSM states: EMPTY (count=0), STREAM (count>0), HALT; EMPTY<->STREAM follows count after push/pop; HALT is left only by flush or reset, going to EMPTY.
REQ-022 In HALT, pushes SHALL be ignored; pops SHALL continue until the FIFO drains; out_valid follows occupancy.
REQ-023 out_valid SHALL equal (count != 0); out_* SHALL reflect the head entry combinationally from FIFO storage.
REQ-024 A pop SHALL occur on out_valid && out_ready; out_* SHALL stay stable while out_valid && !out_ready.
REQ-025 Latency: an entry pushed in cycle N, into an empty FIFO, SHALL appear on out_valid in cycle N+1; no same-cycle bypass.
REQ-026 Simultaneous push and pop SHALL update count by (pushed - 1); pointers SHALL wrap modulo DEPTH.
REQ-027 An expected-order register SHALL load (order+1) mod 256 on every pop; the first pop after reset or flush SHALL not be compared.
REQ-028 On any later pop with out_order != expected order, order_err SHALL set; order 255 followed by 0 is legal.
REQ-029 flush SHALL take priority over same-cycle push and pop.

Reset
REQ-030 On reset assertion, independent of clk, the block SHALL force count=0, pointers=0, state=EMPTY, overflow=0, order_err=0, and clear the first-pop marker.
REQ-031 Outputs during reset: out_valid=0; out_* data are don't-care but deterministic (storage is not reset).
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries; no pop is reported.

Structure
REQ-033 Package rvfi_seq_pkg SHALL hold the entry struct {order, insn, pre_pc, post_pc, trap}, the FSM state enum and the ORDER_W=8 constant.
REQ-034 The FIFO storage and pointers SHALL be one sub-module, rvfi_seq_fifo, with multi-write (up to NRET) and single-read ports; FSM, admission and order tracking stay in the top.

Verification (NRET=2, DEPTH=4)
REQ-035 Channel 0 (order 5) and channel 1 (order 6) valid in one cycle, out_ready=1 -> order 5 emitted at N+1, order 6 at N+2, no flags.
REQ-036 out_ready=0; three groups of 2 in consecutive cycles -> first two accepted, count=4, third dropped, overflow=1, state HALT; later pushes ignored; drain emits 4 entries.
REQ-037 count=3 with a pop and a 1-channel push in the same cycle -> count stays 3, emitted sequence intact.
REQ-038 Orders 254, 255, 0 emitted in sequence -> order_err=0; next entry order 2 -> order_err=1.
REQ-039 Reset asserted between clock edges with count=2 -> out_valid=0 immediately; after release first emitted entry is not order-checked.
REQ-040 flush in the same cycle as a push and pop -> count=0, state EMPTY, flags clear, pushed group discarded.
